// File: rtl/quadencoder_index_homer.sv
// Homing sequencer for one quadrature encoder: arms the index capture, waits for the
// arm/hit handshake on indexout, snapshots the pre-zero position and enforces a timeout.
module quadencoder_index_homer #(
    parameter int unsigned BITS           = 32,
    parameter int unsigned TIMEOUT_BITS   = 32,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    home_req,
    input  logic                    home_abort,
    input  logic [TIMEOUT_BITS-1:0] timeout_cycles,
    input  logic                    enc_indexout,
    input  logic signed [BITS-1:0]  enc_position,
    output logic                    enc_indexenable,
    output logic                    busy,
    output logic                    homed,
    output logic                    done,
    output logic                    fault,
    output logic [1:0]              fault_code,
    output logic signed [BITS-1:0]  index_position,
    output logic [15:0]             home_count
);

    localparam int unsigned RC_W      = $clog2(RELEASE_CYCLES + 1);
    localparam logic [1:0]  CODE_ARM  = 2'd1;
    localparam logic [1:0]  CODE_HIT  = 2'd2;
    localparam logic [1:0]  CODE_ABRT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM_WAIT,
        S_HIT_WAIT,
        S_RELEASE,
        S_FAULT
    } state_t;

    state_t                   state_q, state_d;
    logic [TIMEOUT_BITS-1:0]  elapsed_q, elapsed_d, elapsed_inc;
    logic signed [BITS-1:0]   snap_q, snap_d;
    logic [RC_W-1:0]          rel_cnt_q, rel_cnt_d;
    logic                     en_d, busy_d, homed_d, done_d, fault_d;
    logic [1:0]               code_d;
    logic signed [BITS-1:0]   idx_d;
    logic [15:0]              count_d;
    logic                     tmo_hit, fault_go;
    logic [1:0]               fault_sel;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            elapsed_q       <= '0;
            snap_q          <= '0;
            rel_cnt_q       <= '0;
            enc_indexenable <= 1'b0;
            busy            <= 1'b0;
            homed           <= 1'b0;
            done            <= 1'b0;
            fault           <= 1'b0;
            fault_code      <= 2'd0;
            index_position  <= '0;
            home_count      <= 16'd0;
        end else begin
            state_q         <= state_d;
            elapsed_q       <= elapsed_d;
            snap_q          <= snap_d;
            rel_cnt_q       <= rel_cnt_d;
            enc_indexenable <= en_d;
            busy            <= busy_d;
            homed           <= homed_d;
            done            <= done_d;
            fault           <= fault_d;
            fault_code      <= code_d;
            index_position  <= idx_d;
            home_count      <= count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        elapsed_d   = elapsed_q;
        snap_d      = snap_q;
        rel_cnt_d   = rel_cnt_q;
        en_d        = enc_indexenable;
        busy_d      = busy;
        homed_d     = homed;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        code_d      = fault_code;
        idx_d       = index_position;
        count_d     = home_count;
        fault_go    = 1'b0;
        fault_sel   = 2'd0;
        elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + TIMEOUT_BITS'(1);
        // Equality compare: lowering the limit below elapsed never fires
        tmo_hit     = (timeout_cycles != '0) &&
                      (elapsed_q == timeout_cycles - TIMEOUT_BITS'(1));

        case (state_q)
            S_IDLE: begin
                if (home_req) begin
                    state_d   = S_ARM_WAIT;
                    en_d      = 1'b1;
                    busy_d    = 1'b1;
                    homed_d   = 1'b0;
                    code_d    = 2'd0;
                    elapsed_d = '0;
                end
            end
            S_ARM_WAIT: begin
                if (home_abort) begin
                    fault_go  = 1'b1;
                    fault_sel = CODE_ABRT;
                end else if (enc_indexout) begin
                    state_d   = S_HIT_WAIT;
                    elapsed_d = elapsed_inc;
                end else if (tmo_hit) begin
                    fault_go  = 1'b1;
                    fault_sel = CODE_ARM;
                end else begin
                    elapsed_d = elapsed_inc;
                end
            end
            S_HIT_WAIT: begin
                snap_d = enc_position;
                if (home_abort) begin
                    fault_go  = 1'b1;
                    fault_sel = CODE_ABRT;
                end else if (!enc_indexout) begin
                    // Encoder has already zeroed this cycle; keep the prior sample
                    idx_d     = snap_q;
                    en_d      = 1'b0;
                    rel_cnt_d = '0;
                    state_d   = S_RELEASE;
                end else if (tmo_hit) begin
                    fault_go  = 1'b1;
                    fault_sel = CODE_HIT;
                end else begin
                    elapsed_d = elapsed_inc;
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == RC_W'(RELEASE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    homed_d = 1'b1;
                    busy_d  = 1'b0;
                    count_d = home_count + 16'd1;
                end else begin
                    rel_cnt_d = rel_cnt_q + RC_W'(1);
                end
            end
            S_FAULT: begin
                if (rel_cnt_q == RC_W'(RELEASE_CYCLES)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    rel_cnt_d = rel_cnt_q + RC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (fault_go) begin
            state_d   = S_FAULT;
            fault_d   = 1'b1;
            en_d      = 1'b0;
            homed_d   = 1'b0;
            code_d    = fault_sel;
            rel_cnt_d = '0;
        end
    end

endmodule
